// File: rtl/spi_master.sv
// SPI master: single-word or multi-word frames, configurable CPOL/CPHA and SCLK divider.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first (default MSB first).
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_SCLK,
  output logic              spi_MOSI,
  input  logic              spi_MISO,
  output logic              spi_SS_n
);

  localparam int                 CNT_W     = $clog2(CLK_DIV + 1);
  localparam int                 EDGE_W    = $clog2(2 * DATA_W + 1);
  localparam logic               SCLK_IDLE = (CPOL != 0);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0]  EDGE_LAST = EDGE_W'(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, WAIT, TRAIL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                ss_n_q, ss_n_d;
  logic                ready_q, ready_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;

  logic                accept, tick, odd, sample, advance;
  logic [EDGE_W-1:0]   edge_num;
  logic [DATA_W-1:0]   rx_next;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {1'b0, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {b, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], b};
`endif
  endfunction

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      sclk_q     <= SCLK_IDLE;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      ready_q    <= 1'b0;
      last_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      ready_q    <= ready_d;
      last_q     <= last_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    last_d     = last_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    accept   = tx_valid && ready_q;
    tick     = (cnt_q == CNT_MAX);
    edge_num = edge_q + EDGE_W'(1);
    odd      = edge_num[0];
    sample   = (CPHA == 0) ? odd : ~odd;
    advance  = (CPHA == 0) ? (~odd && (edge_num != EDGE_LAST)) : odd;
    rx_next  = sample ? shift_in(rx_sh_q, spi_MISO) : rx_sh_q;

    case (state_q)
      IDLE, WAIT: begin
        if (accept) begin
          state_d = LEAD;
          cnt_d   = '0;
          edge_d  = '0;
          ss_n_d  = 1'b0;
          last_d  = tx_last;
          rx_sh_d = '0;
          // CPHA=0 presents the first bit before the first SCLK edge
          if (CPHA == 0) begin
            mosi_d  = first_bit(tx_data);
            tx_sh_d = shift_out(tx_data);
          end else begin
            mosi_d  = 1'b0;
            tx_sh_d = tx_data;
          end
        end
      end
      LEAD, SHIFT: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = ~sclk_q;
          edge_d  = edge_num;
          rx_sh_d = rx_next;
          if (advance) begin
            mosi_d  = first_bit(tx_sh_q);
            tx_sh_d = shift_out(tx_sh_q);
          end
          if (edge_num == EDGE_LAST) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            state_d    = last_q ? TRAIL : WAIT;
          end
        end
      end
      TRAIL: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          state_d = IDLE;
          ss_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == WAIT);
  end

  assign tx_ready = ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = ~ss_n_q;
  assign spi_SCLK = sclk_q;
  assign spi_MOSI = mosi_q;
  assign spi_SS_n = ss_n_q;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, word length in bits (legal 4..32).
REQ-002 SHALL provide parameter CLK_DIV, default 4, clk_clk cycles per SCLK half-period (legal >=1).
REQ-003 SHALL provide parameter CPOL, default 0, SCLK idle level.
REQ-004 SHALL provide parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 Ports SHALL be:
- clk_clk  in  1  sole clock, all logic rising-edge.
- reset_reset_n  in  1  synchronous, active-low reset.
- tx_data  in  DATA_W  word to transmit.
- tx_last  in  1  with tx_data; 1 = release SS_n after this word.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_ready  out  1  block accepts a word this cycle.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- busy  out  1  frame in progress (SS_n low).
- spi_SCLK  out  1  serial clock.
- spi_MOSI  out  1  serial data out.
- spi_MISO  in  1  serial data in.
- spi_SS_n  out  1  slave select, active low.

Function
REQ-006 A word SHALL be accepted on any rising edge with tx_valid=1 and tx_ready=1; tx_data/tx_last latched, no other cycle may latch them.
REQ-007 FSM states SHALL be IDLE, LEAD, SHIFT, WAIT, TRAIL.
REQ-008 IDLE: SS_n=1, SCLK=CPOL, tx_ready=1, busy=0; on accept -> LEAD, SS_n=0 from next cycle.
REQ-009 LEAD SHALL last CLK_DIV cycles with SCLK=CPOL, then -> SHIFT.
REQ-010 SHIFT SHALL produce exactly 2*DATA_W SCLK edges, CLK_DIV cycles apart, first edge CLK_DIV cycles after LEAD entry; SCLK=CPOL after the last edge.
REQ-011 CPHA=0: first bit on MOSI from LEAD entry; MISO sampled on odd edges; MOSI advances on even edges except the last. CPHA=1: MOSI advances on odd edges; MISO sampled on even edges.
REQ-012 Bit order SHALL be MSB first (see REQ-020); received bits shift in so first bit lands in rx_data[DATA_W-1].
REQ-013 The cycle after the final edge rx_data SHALL take the received word and rx_valid SHALL be 1 for exactly one cycle; then -> TRAIL if latched tx_last=1, else -> WAIT.
REQ-014 WAIT: SS_n held 0, SCLK=CPOL, tx_ready=1, busy=1; on accept -> LEAD.
REQ-015 TRAIL SHALL last CLK_DIV cycles with tx_ready=0, then SS_n=1 and -> IDLE.
REQ-016 tx_ready SHALL be 0 in LEAD, SHIFT, TRAIL; tx_valid there is ignored and not latched.
REQ-017 Single word, tx_last=1: SS_n SHALL be low for exactly CLK_DIV*(2*DATA_W+1) cycles.
REQ-018 MOSI SHALL be 0 whenever SS_n=1; all SPI outputs registered, glitch-free.

Reset
REQ-019 While reset_reset_n=0 at a rising edge: state=IDLE, spi_SS_n=1, spi_SCLK=CPOL, spi_MOSI=0, tx_ready=0, busy=0, rx_valid=0, rx_data=0, counters=0; tx_ready=1 from first cycle after release; reset mid-frame aborts with no rx_valid and SS_n=1 in the next cycle.

Configuration
REQ-020 Macro SPI_MASTER_LSB_FIRST_EN: defined -> tx_data[0] transmitted first and first received bit lands in rx_data[0]; undefined -> MSB-first per REQ-012; timing identical in both builds.

Verification
REQ-021 CPOL=0, CPHA=0, CLK_DIV=2, DATA_W=8, MISO looped to MOSI, send 0xA5 tx_last=1 -> rx_data=0xA5, one rx_valid pulse, 8 SCLK rising edges, SS_n low 34 cycles.
REQ-022 Mode 3 (CPOL=1, CPHA=1), MISO tied 1, send 0x3C -> SCLK idles 1, rx_data=0xFF, MOSI bit sequence 0,0,1,1,1,1,0,0.
REQ-023 Send 0x12 tx_last=0 then 0x34 tx_last=1 -> SS_n stays low across both words, two rx_valid pulses, tx_ready=1 only in IDLE/WAIT.
REQ-024 Assert reset_reset_n=0 for one cycle at SCLK edge 5 -> SS_n=1, SCLK=CPOL, no rx_valid; next word transfers normally.
REQ-025 With SPI_MASTER_LSB_FIRST_EN defined, send 0x01 -> MOSI=1 for first bit only; loopback rx_data=0x01.
